vga_src_arbiter: RTL and testbench
==================================

// Module: vga_src_arbiter
// PURPOSE
//  Shares the single VGA RGB output between the six screen renderers (menu, 2048, tetris,
//  snake, win, lose) under the 4-bit screen select from the game control FSM. Switches source
//  only at frame boundaries and inserts blank frames on every switch, so no torn frame appears.
//  Applies the win/lose blink overlay. Sits between the renderers and the VGA timing/pin logic.
// PARAMETERS
//  BLANK_FRAMES  2        black frames inserted on a source switch (0 = switch immediately)
//  BLINK_MASK    6'b110000  bit k-1 set: mode k uses blink overlay (default modes 5,6)
//  BLINK_COLOR   12'h000  colour substituted for visible pixels while blink=1 on a masked mode
// PORTS
//  clk          in   1   system clock
//  clr          in   1   asynchronous active-high reset
//  vga_control  in   4   requested screen: 0 none, 1 menu, 2 2048, 3 tetris, 4 snake, 5 win, 6 lose
//  blink        in   1   blink phase level from control
//  frame_start  in   1   1-cycle pulse at start of vertical blank from VGA timing
//  pix_de       in   1   visible-pixel enable from VGA timing
//  src_rgb      in   72  six 12-bit RGB sources; [12k-1:12(k-1)] = mode k
//  rgb          out  12  registered pixel to VGA pins
//  cur_src      out  3   mode currently driving rgb (0..6)
//  switching    out  1   high while blank frames are being inserted
//  sw_done      out  1   1-cycle pulse when a switch completes (first shown frame begins)
// BEHAVIOUR
//  - Reset (async, clr=1): rgb=0, cur_src=0, switching=0, sw_done=0, state IDLE, blank_cnt=0.
//    clr asserted mid-switch aborts it; after release, a nonzero request is applied at the
//    next frame_start, with blanking.
//  - req = vga_control if in 1..6, else 0 (7..15 treated as 0), sampled every cycle.
//  - States: IDLE (cur_src=0, output black), BLANK, SHOW. All transitions occur only in the
//    cycle frame_start=1; otherwise state, cur_src and blank_cnt hold.
//  - At frame_start, req != cur_src: cur_src<=req; if req==0 -> IDLE, switching=0;
//    elif BLANK_FRAMES==0 -> SHOW, sw_done=1; else -> BLANK, blank_cnt<=BLANK_FRAMES-1, switching=1.
//  - At frame_start in BLANK, req==cur_src: blank_cnt==0 -> SHOW, switching<=0, sw_done=1
//    for that one cycle; else blank_cnt<=blank_cnt-1.
//  - Request changing again during BLANK: new req wins at next frame_start, blank_cnt reloads
//    (blank period restarts; no sw_done for the abandoned target).
//  - req==cur_src at frame_start in SHOW/IDLE: no change, no pulse.
//  - Pixel path, latency 1 cycle: rgb <= 0 if pix_de=0 or state!=SHOW; else if
//    BLINK_MASK[cur_src-1] and blink=1 -> BLINK_COLOR; else src_rgb slice for cur_src.
//    The pixel in the frame_start cycle uses the pre-update cur_src and state.
//  - blink is a level; it is not synchronised to frames (overlay may toggle mid-frame).
//  - sw_done and switching are registered, asserted the cycle after the deciding frame_start.
// TESTING
//  T1 reset: clr=1 with pix_de=1, src_rgb all 12'hFFF -> rgb=0, cur_src=0, switching=0.
//  T2 switch: vga_control 0->2, BLANK_FRAMES=2; three frame_start pulses -> cur_src=2 after 1st,
//     switching=1 for 2 frames, sw_done 1 cycle after 3rd, then rgb=src_rgb[23:12] 1 cycle after pix_de.
//  T3 mid-frame request: vga_control 2->3 between frame_starts -> rgb stays source 2 until
//     next frame_start, then black for 2 frames, then source 3.
//  T4 retarget in blank: 1->4, then to 6 during first blank frame -> no sw_done for 4,
//     blank restarts, cur_src=6, sw_done after 2 further blank frames.
//  T5 blink: mode 5 showing, src=12'hABC, blink 0->1->0 -> rgb ABC, 000, ABC; mode 3 with blink=1 -> src unchanged.
//  T6 invalid/idle: vga_control=4'd9 and pix_de=1 -> at frame_start cur_src=0, rgb=0; clr during BLANK -> IDLE, switching=0 at once.

Source files
------------

// File: rtl/vga_src_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_src_arbiter
// Purpose  : Chooses which of the six screen renderers drives the VGA RGB
//            output. The source changes only on frame_start, and black frames
//            are inserted on every change so no frame is ever torn. Also
//            applies the win/lose blink overlay.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1   system clock
//   clr          in   1   asynchronous active-high reset
//   vga_control  in   4   requested screen (1..6 valid, anything else = none)
//   blink        in   1   blink phase level
//   frame_start  in   1   1-cycle pulse at start of vertical blank
//   pix_de       in   1   visible-pixel enable
//   src_rgb      in   72  six 12-bit sources, [12k-1:12(k-1)] = mode k
//   rgb          out  12  registered pixel to the VGA pins
//   cur_src      out  3   mode currently selected (0..6)
//   switching    out  1   high while blank frames are being inserted
//   sw_done      out  1   1-cycle pulse when the first shown frame begins
// ============================================================================
module vga_src_arbiter #(
  parameter int unsigned BLANK_FRAMES = 2,
  parameter logic [5:0]  BLINK_MASK   = 6'b110000,
  parameter logic [11:0] BLINK_COLOR  = 12'h000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [3:0]  vga_control,
  input  logic        blink,
  input  logic        frame_start,
  input  logic        pix_de,
  input  logic [71:0] src_rgb,
  output logic [11:0] rgb,
  output logic [2:0]  cur_src,
  output logic        switching,
  output logic        sw_done
);

  localparam int CNT_W = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;
  // Counter holds "frames still to blank after the current one".
  localparam logic [CNT_W-1:0] c_RELOAD =
      CNT_W'((BLANK_FRAMES > 0) ? BLANK_FRAMES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_blank_cnt, w_cnt_nxt;
  logic [2:0]       w_req, w_src_nxt;
  logic             w_switching_nxt, w_sw_done_nxt;
  logic [11:0]      w_rgb_nxt, w_src_pix;
  logic             w_blink_en;

  // Out-of-range requests collapse to "no screen".
  assign w_req = (vga_control >= 4'd1 && vga_control <= 4'd6) ? vga_control[2:0] : 3'd0;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state     <= S_IDLE;
      r_blank_cnt <= '0;
      cur_src     <= 3'd0;
      switching   <= 1'b0;
      sw_done     <= 1'b0;
      rgb         <= 12'h000;
    end else begin
      r_state     <= w_state_nxt;
      r_blank_cnt <= w_cnt_nxt;
      cur_src     <= w_src_nxt;
      switching   <= w_switching_nxt;
      sw_done     <= w_sw_done_nxt;
      rgb         <= w_rgb_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic: every decision is taken in the frame_start cycle only.
  // A changed request always wins, even mid-blank, which restarts blanking.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_blank_cnt;
    w_src_nxt       = cur_src;
    w_switching_nxt = switching;
    w_sw_done_nxt   = 1'b0;
    if (frame_start) begin
      if (w_req != cur_src) begin
        w_src_nxt = w_req;
        if (w_req == 3'd0) begin
          w_state_nxt     = S_IDLE;
          w_switching_nxt = 1'b0;
        end else if (BLANK_FRAMES == 0) begin
          w_state_nxt     = S_SHOW;
          w_switching_nxt = 1'b0;
          w_sw_done_nxt   = 1'b1;
        end else begin
          w_state_nxt     = S_BLANK;
          w_cnt_nxt       = c_RELOAD;
          w_switching_nxt = 1'b1;
        end
      end else if (r_state == S_BLANK) begin
        if (r_blank_cnt == '0) begin
          w_state_nxt     = S_SHOW;
          w_switching_nxt = 1'b0;
          w_sw_done_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_blank_cnt - CNT_W'(1);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pixel path: uses the registered (pre-update) source and state, so the
  // frame_start pixel still belongs to the old frame.
  // --------------------------------------------------------------------------
  always_comb begin
    w_src_pix  = 12'h000;
    w_blink_en = 1'b0;
    case (cur_src)
      3'd1: begin w_src_pix = src_rgb[11:0];  w_blink_en = BLINK_MASK[0]; end
      3'd2: begin w_src_pix = src_rgb[23:12]; w_blink_en = BLINK_MASK[1]; end
      3'd3: begin w_src_pix = src_rgb[35:24]; w_blink_en = BLINK_MASK[2]; end
      3'd4: begin w_src_pix = src_rgb[47:36]; w_blink_en = BLINK_MASK[3]; end
      3'd5: begin w_src_pix = src_rgb[59:48]; w_blink_en = BLINK_MASK[4]; end
      3'd6: begin w_src_pix = src_rgb[71:60]; w_blink_en = BLINK_MASK[5]; end
      default: begin w_src_pix = 12'h000; w_blink_en = 1'b0; end
    endcase
  end

  always_comb begin
    w_rgb_nxt = 12'h000;
    if (pix_de && r_state == S_SHOW) begin
      w_rgb_nxt = (w_blink_en && blink) ? BLINK_COLOR : w_src_pix;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_src_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_src_arbiter
// Purpose  : Randomised self-checking bench for vga_src_arbiter. A frame-level
//            reference model (shown mode, blanking flag, frames left before
//            display) predicts every output each cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_vga_src_arbiter;

  localparam int unsigned BF     = 2;
  localparam logic [5:0]  MASK   = 6'b110000;
  localparam logic [11:0] BCOLOR = 12'h000;
  localparam int          NCYC   = 6000;

  logic        clk = 1'b0;
  logic        clr;
  logic [3:0]  vga_control;
  logic        blink;
  logic        frame_start;
  logic        pix_de;
  logic [71:0] src_rgb;
  logic [11:0] rgb;
  logic [2:0]  cur_src;
  logic        switching;
  logic        sw_done;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int m_src;       // selected mode, 0 = none
  bit m_blanking;  // inserting black frames
  bit m_showing;   // selected source visible
  int m_left;      // frame_starts still needed before the source shows

  vga_src_arbiter #(
    .BLANK_FRAMES(BF),
    .BLINK_MASK  (MASK),
    .BLINK_COLOR (BCOLOR)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .vga_control(vga_control),
    .blink      (blink),
    .frame_start(frame_start),
    .pix_de     (pix_de),
    .src_rgb    (src_rgb),
    .rgb        (rgb),
    .cur_src    (cur_src),
    .switching  (switching),
    .sw_done    (sw_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_src      = 0;
    m_blanking = 0;
    m_showing  = 0;
    m_left     = 0;
  endtask

  function automatic logic [11:0] exp_pixel();
    if (!pix_de || !m_showing || m_src == 0) return 12'h000;
    if (blink && MASK[m_src-1]) return BCOLOR;
    return src_rgb[12*m_src-12 +: 12];
  endfunction

  initial begin
    logic [11:0] e_rgb;
    bit          e_done;
    int          req;
    int          frame_len;
    int          frame_pos;

    clr = 1'b1; vga_control = 4'd0; blink = 1'b0; frame_start = 1'b0;
    pix_de = 1'b1; src_rgb = {72{1'b1}};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_rgb",       32'(rgb),       32'h0);
    check("reset_cur_src",   32'(cur_src),   32'h0);
    check("reset_switching", 32'(switching), 32'h0);
    check("reset_sw_done",   32'(sw_done),   32'h0);

    frame_len = 6;
    frame_pos = 0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      clr = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 14) == 0) begin
        if ($urandom_range(0, 3) == 0) vga_control = 4'($urandom_range(0, 15));
        else                           vga_control = 4'($urandom_range(1, 6));
      end
      frame_start = (frame_pos == 0);
      frame_pos++;
      if (frame_pos >= frame_len) begin
        frame_pos = 0;
        frame_len = $urandom_range(3, 9);
      end
      pix_de  = ($urandom_range(0, 3) != 0);
      blink   = ($urandom_range(0, 5) == 0) ? ~blink : blink;
      src_rgb = {8'($urandom), 32'($urandom), 32'($urandom)};

      if (clr) begin
        // Asynchronous reset: outputs must clear before any clock edge.
        #1;
        model_reset();
        check("async_rgb",       32'(rgb),       32'h0);
        check("async_cur_src",   32'(cur_src),   32'h0);
        check("async_switching", 32'(switching), 32'h0);
        check("async_sw_done",   32'(sw_done),   32'h0);
        continue;
      end

      @(posedge clk);
      e_rgb  = exp_pixel();
      e_done = 0;
      req    = (vga_control >= 1 && vga_control <= 6) ? int'(vga_control) : 0;
      if (frame_start) begin
        if (req != m_src) begin
          m_src      = req;
          m_showing  = 0;
          m_blanking = (req != 0);
          m_left     = BF;
          if (req != 0 && BF == 0) begin
            m_blanking = 0;
            m_showing  = 1;
            e_done     = 1;
          end
        end else if (m_blanking) begin
          m_left--;
          if (m_left == 0) begin
            m_blanking = 0;
            m_showing  = 1;
            e_done     = 1;
          end
        end
      end
      #1;
      check("rgb",       32'(rgb),       32'(e_rgb));
      check("cur_src",   32'(cur_src),   32'(m_src));
      check("switching", 32'(switching), 32'(m_blanking));
      check("sw_done",   32'(sw_done),   32'(e_done));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
